conv_enc_framer: RTL and testbench

CONV_ENC_FRAMER -- requirements
Module: conv_enc_framer

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_enc_core.sv | 34 +++
 rtl/conv_enc_framer.sv | 141 ++++++++++++++
 tb/tb_conv_enc_framer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the rate-1/2, K=3 convolutional encoder framer:
// FSM state encoding, code constraint length, generator polynomials and
// the symbol width, plus a helper that forms one coded symbol.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int K = 3;

  // Generator taps ordered {current bit, d1, d2}: 7 octal and 5 octal.
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  localparam int SIZE_OUT = 2;

  // One coded symbol {g0,g1} from the tap vector {b, d1, d2}.
  function automatic logic [SIZE_OUT-1:0] conv_symbol(input logic [K-1:0] taps);
    conv_symbol = {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Convolutional encoder core: the K-1 bit history register {d1,d2} and the
// generator XOR network. The symbol output is combinational on the bit being
// presented; the history only moves when the symbol is taken (shift_en).
module conv_enc_core
  import conv_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shift_en,
  input  logic                          clear,
  input  logic                          bit_in,
  output logic [conv_pkg::SIZE_OUT-1:0] symbol
);

  // {d1,d2}: d1 is the most recent bit that has been encoded and accepted.
  logic [K-2:0] history;

  // History register: clear wins over shift so a new frame starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
    end else if (clear) begin
      history <= '0;
    end else if (shift_en) begin
      history <= {bit_in, history[K-2:1]};
    end
  end

  // Coded symbol for the bit currently on offer.
  always_comb begin
    symbol = conv_symbol({bit_in, history});
  end

endmodule

// File: rtl/conv_enc_framer.sv
// Byte framer for the rate-1/2 convolutional encoder. Accepts one byte, sends
// its bits LSB first through the encoder as a valid/ready symbol stream, then
// pulses o_frame_done for one cycle before accepting the next byte.
//
// Build option CONV_ENC_TAIL_EN: when defined, every frame is followed by
// TAIL_LEN zero flush bits and the encoder history is cleared at each frame
// start. When undefined, frames are SIZE_DATA symbols and the history carries
// across frames (only reset clears it).
module conv_enc_framer
  import conv_pkg::*;
#(
  parameter int SIZE_DATA = 8,
  parameter int SIZE_OUT  = conv_pkg::SIZE_OUT,
  parameter int TAIL_LEN  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic                 o_ready,
  output logic [SIZE_OUT-1:0]  o_conv_data,
  output logic                 o_conv_valid,
  input  logic                 i_conv_ready,
  output logic                 o_frame_done,
  output logic                 o_busy
);

  // State table
  //   IDLE | waiting for a byte, o_ready high
  //   DATA | streaming the SIZE_DATA data bits, LSB first
  //   TAIL | streaming TAIL_LEN zero flush bits (tail build only)
  //   DONE | one-cycle frame-end pulse, no symbol valid

  localparam int CNT_W = $clog2(SIZE_DATA + TAIL_LEN);
  localparam int IDX_W = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(SIZE_DATA - 1);
`ifdef CONV_ENC_TAIL_EN
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(SIZE_DATA + TAIL_LEN - 1);
`endif

  state_t                         state;
  logic [CNT_W-1:0]               bit_cnt;
  logic [SIZE_DATA-1:0]           data_q;
  logic                           accept;
  logic                           handshake;
  logic                           cur_bit;
  logic                           hist_clear;
  logic [conv_pkg::SIZE_OUT-1:0]  symbol;

  // Handshake qualifiers and the bit presented to the encoder; tail bits
  // are zero because only DATA selects from the latched byte.
  always_comb begin
    accept    = i_start & o_ready;
    handshake = o_conv_valid & i_conv_ready;
    cur_bit   = (state == DATA) ? data_q[bit_cnt[IDX_W-1:0]] : 1'b0;
`ifdef CONV_ENC_TAIL_EN
    hist_clear = accept;
`else
    hist_clear = 1'b0;
`endif
  end

  conv_enc_core u_core (
    .clk      (i_clk),
    .rst      (i_rst),
    .shift_en (handshake),
    .clear    (hist_clear),
    .bit_in   (cur_bit),
    .symbol   (symbol)
  );

  // Symbol output is forced to zero whenever nothing is on offer; it is
  // built only from registers, so it stays put while the sink stalls.
  always_comb begin
    o_conv_data = o_conv_valid ? SIZE_OUT'(symbol) : '0;
  end

  // Frame sequencer with registered status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      data_q       <= '0;
      o_conv_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
      o_ready      <= 1'b1;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= DATA;
            data_q       <= i_data;
            bit_cnt      <= '0;
            o_conv_valid <= 1'b1;
            o_busy       <= 1'b1;
            o_ready      <= 1'b0;
          end
        end
        DATA: begin
          if (handshake) begin
            if (bit_cnt == LAST_DATA) begin
`ifdef CONV_ENC_TAIL_EN
              state   <= TAIL;
              bit_cnt <= bit_cnt + CNT_W'(1);
`else
              state        <= DONE;
              o_conv_valid <= 1'b0;
              o_frame_done <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
`ifdef CONV_ENC_TAIL_EN
        TAIL: begin
          if (handshake) begin
            if (bit_cnt == LAST_TAIL) begin
              state        <= DONE;
              o_conv_valid <= 1'b0;
              o_frame_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
`endif
        default: begin
          // DONE (and any unreachable encoding) returns to IDLE after one cycle.
          state        <= IDLE;
          o_conv_valid <= 1'b0;
          o_busy       <= 1'b0;
          o_ready      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc_framer.sv
// Self-checking bench for conv_enc_framer. Expected symbols come from a
// bit-level model of the K=3 (7,5) code; honours CONV_ENC_TAIL_EN.
`timescale 1ns/1ps
module tb_conv_enc_framer;

  localparam int SIZE_DATA = 8;
  localparam int SIZE_OUT  = 2;
  localparam int TAIL_LEN  = 2;
`ifdef CONV_ENC_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif
  localparam int NSYM  = TAIL_EN ? SIZE_DATA + TAIL_LEN : SIZE_DATA;
  localparam int LIMIT = 400;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_start;
  logic [SIZE_DATA-1:0] i_data;
  logic                 o_ready;
  logic [SIZE_OUT-1:0]  o_conv_data;
  logic                 o_conv_valid;
  logic                 i_conv_ready;
  logic                 o_frame_done;
  logic                 o_busy;

  conv_enc_framer #(
    .SIZE_DATA (SIZE_DATA),
    .SIZE_OUT  (SIZE_OUT),
    .TAIL_LEN  (TAIL_LEN)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_conv_data  (o_conv_data),
    .o_conv_valid (o_conv_valid),
    .i_conv_ready (i_conv_ready),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int passed = 0;

  // Reference encoder history: m_d1 most recent bit.
  bit m_d1, m_d2;
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  int done_cycle, done_count, stall_count;
  bit held_ok, flags_ok, timed_out;

  // Append the expected symbols of one frame and advance the model history.
  task automatic model_frame(input logic [7:0] d);
    bit b;
    if (TAIL_EN) begin
      m_d1 = 1'b0;
      m_d2 = 1'b0;
    end
    for (int i = 0; i < NSYM; i++) begin
      b = (i < SIZE_DATA) ? d[i] : 1'b0;
      exp_q.push_back({b ^ m_d1 ^ m_d2, b ^ m_d2});
      m_d2 = m_d1;
      m_d1 = b;
    end
  endtask

  // Runs one frame from an IDLE sample point and records what the DUT did.
  // stall_at >= 0 forces stall_len stall cycles while that symbol is offered;
  // otherwise i_conv_ready drops randomly with probability stall_pct.
  task automatic drive_frame(input logic [7:0] d, input int stall_pct,
                             input int stall_at, input int stall_len, input bit noise);
    logic [1:0] prev;
    bit have_prev;
    int forced;
    exp_q.delete();
    model_frame(d);
    i_data  = d;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    obs_q.delete();
    done_cycle = -1; done_count = 0; stall_count = 0;
    held_ok = 1'b1; flags_ok = 1'b1; timed_out = 1'b1;
    have_prev = 1'b0; forced = 0; prev = '0;
    for (int cyc = 1; cyc <= LIMIT; cyc++) begin
      if (o_frame_done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = cyc;
        if (o_conv_valid) flags_ok = 1'b0;
      end
      if (done_cycle >= 0 && cyc == done_cycle + 1) begin
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_conv_valid !== 1'b0 || o_frame_done !== 1'b0)
          flags_ok = 1'b0;
        timed_out = 1'b0;
        break;
      end
      if (o_busy !== 1'b1 || o_ready !== 1'b0) flags_ok = 1'b0;
      if (stall_at >= 0) begin
        i_conv_ready = !(obs_q.size() == stall_at && forced < stall_len);
        if (!i_conv_ready && o_conv_valid) forced++;
      end else begin
        i_conv_ready = ($urandom_range(99) >= stall_pct);
      end
      if (noise) begin
        i_start = 1'($urandom_range(1));
        i_data  = 8'($urandom_range(255));
      end
      if (o_conv_valid) begin
        if (have_prev && o_conv_data !== prev) held_ok = 1'b0;
        if (i_conv_ready) begin
          obs_q.push_back(o_conv_data);
          have_prev = 1'b0;
        end else begin
          prev = o_conv_data;
          have_prev = 1'b1;
          stall_count++;
        end
      end else if (have_prev) begin
        held_ok = 1'b0;
      end
      @(posedge i_clk); #1;
    end
    i_start = 1'b0;
    i_conv_ready = 1'b1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_data = '0; i_conv_ready = 1'b1;
    m_d1 = 1'b0; m_d2 = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", o_ready); else passed++;
    checks++; if (o_conv_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_conv_valid); else passed++;
    checks++; if (o_conv_data !== 2'b00) $display("FAIL reset_data: got %b expected 00", o_conv_data); else passed++;
    checks++; if (o_frame_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", o_frame_done); else passed++;
    checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_busy); else passed++;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (o_ready !== 1'b1 || o_conv_valid !== 1'b0)
      $display("FAIL post_reset_idle: ready=%b valid=%b expected ready=1 valid=0", o_ready, o_conv_valid);
    else passed++;
  endtask

  // Fixed corner bytes then random bytes, sink always ready.
  task automatic test_patterns();
    logic [7:0] d;
    for (int n = 0; n < 8; n++) begin
      d = (n == 0) ? 8'h00 : (n == 1) ? 8'h01 : (n == 2) ? 8'hFF : 8'($urandom_range(255));
      drive_frame(d, 0, -1, 0, 1'b0);
      checks++; if (timed_out) $display("FAIL pattern_timeout data=%02h: no frame_done within %0d cycles", d, LIMIT); else passed++;
      checks++; if (obs_q.size() != exp_q.size()) $display("FAIL pattern_len data=%02h: got %0d expected %0d", d, obs_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL pattern_sym data=%02h idx=%0d: got %b expected %b", d, i, obs_q[i], exp_q[i]);
        else passed++;
      end
      checks++; if (done_cycle != NSYM + 1) $display("FAIL pattern_done_cycle data=%02h: got %0d expected %0d", d, done_cycle, NSYM + 1); else passed++;
      checks++; if (done_count != 1) $display("FAIL pattern_done_count data=%02h: got %0d expected 1", d, done_count); else passed++;
      checks++; if (!flags_ok) $display("FAIL pattern_flags data=%02h: ready/busy/valid wrong during frame", d); else passed++;
    end
  endtask

  // Deterministic 3-cycle stall on the second symbol of 0x01, then random stalls.
  task automatic test_backpressure();
    logic [7:0] d;
    for (int n = 0; n < 5; n++) begin
      d = (n == 0) ? 8'h01 : 8'($urandom_range(255));
      if (n == 0) drive_frame(d, 0, 1, 3, 1'b0);
      else        drive_frame(d, 40, -1, 0, 1'b0);
      checks++; if (timed_out) $display("FAIL bp_timeout data=%02h: no frame_done within %0d cycles", d, LIMIT); else passed++;
      checks++; if (!held_ok) $display("FAIL bp_hold data=%02h: symbol changed or dropped while stalled", d); else passed++;
      if (n == 0) begin
        checks++; if (stall_count != 3) $display("FAIL bp_stall_count: got %0d expected 3", stall_count); else passed++;
      end
      checks++; if (obs_q.size() != exp_q.size()) $display("FAIL bp_len data=%02h: got %0d expected %0d", d, obs_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL bp_sym data=%02h idx=%0d: got %b expected %b", d, i, obs_q[i], exp_q[i]);
        else passed++;
      end
      checks++;
      if (done_cycle != NSYM + stall_count + 1)
        $display("FAIL bp_done_cycle data=%02h: got %0d expected %0d", d, done_cycle, NSYM + stall_count + 1);
      else passed++;
    end
  endtask

  // i_start pulsed with junk data while a frame runs must change nothing.
  task automatic test_start_ignored();
    logic [7:0] d;
    for (int n = 0; n < 3; n++) begin
      d = 8'($urandom_range(255));
      drive_frame(d, 20, -1, 0, 1'b1);
      checks++; if (timed_out) $display("FAIL ign_timeout data=%02h", d); else passed++;
      checks++; if (!flags_ok) $display("FAIL ign_flags data=%02h: ready/busy/valid wrong during frame", d); else passed++;
      checks++; if (obs_q.size() != exp_q.size()) $display("FAIL ign_len data=%02h: got %0d expected %0d", d, obs_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL ign_sym data=%02h idx=%0d: got %b expected %b", d, i, obs_q[i], exp_q[i]);
        else passed++;
      end
    end
  endtask

  // i_start held high: three frames, each separated by non-valid cycles.
  task automatic test_back_to_back();
    logic [7:0] d;
    int dones;
    bit overlap;
    d = 8'($urandom_range(255));
    exp_q.delete();
    obs_q.delete();
    repeat (3) model_frame(d);
    dones = 0; overlap = 1'b0;
    i_data = d; i_start = 1'b1; i_conv_ready = 1'b1;
    for (int cyc = 1; cyc <= 3 * (NSYM + 2); cyc++) begin
      @(posedge i_clk); #1;
      if (o_conv_valid) obs_q.push_back(o_conv_data);
      if (o_conv_valid && (o_ready || o_frame_done)) overlap = 1'b1;
      if (o_frame_done) begin
        dones++;
        if (dones == 3) i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    checks++; if (dones != 3) $display("FAIL b2b_done_count: got %0d expected 3", dones); else passed++;
    checks++; if (overlap) $display("FAIL b2b_gap: valid seen in IDLE or DONE cycle"); else passed++;
    checks++; if (o_ready !== 1'b1) $display("FAIL b2b_final_ready: got %b expected 1", o_ready); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_len: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_sym idx=%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  // Reset asserted while the fourth symbol of 0xFF is on offer.
  task automatic test_mid_frame_reset();
    i_data = 8'hFF; i_start = 1'b1; i_conv_ready = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (3) begin
      @(posedge i_clk); #1;
    end
    checks++; if (o_conv_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b expected 1", o_conv_valid); else passed++;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_conv_valid !== 1'b0 || o_conv_data !== 2'b00 || o_frame_done !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1)
      $display("FAIL mid_reset_outputs: valid=%b data=%b done=%b busy=%b ready=%b expected 0 00 0 0 1",
               o_conv_valid, o_conv_data, o_frame_done, o_busy, o_ready);
    else passed++;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    m_d1 = 1'b0; m_d2 = 1'b0;
    @(posedge i_clk); #1;
    checks++; if (o_conv_valid !== 1'b0 || o_ready !== 1'b1) $display("FAIL mid_no_resume: valid=%b ready=%b expected 0 1", o_conv_valid, o_ready); else passed++;
    drive_frame(8'h00, 0, -1, 0, 1'b0);
    checks++; if (obs_q.size() != NSYM) $display("FAIL mid_after_len: got %0d expected %0d", obs_q.size(), NSYM); else passed++;
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== 2'b00) $display("FAIL mid_after_sym idx=%0d: got %b expected 00", i, obs_q[i]);
      else passed++;
    end
  endtask

  // 0xFF then 0x00 from reset: history either flushed or carried over.
  task automatic test_carry_over();
    logic [1:0] want;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    m_d1 = 1'b0; m_d2 = 1'b0;
    @(posedge i_clk); #1;
    drive_frame(8'hFF, 0, -1, 0, 1'b0);
    drive_frame(8'h00, 0, -1, 0, 1'b0);
    checks++; if (obs_q.size() != NSYM) $display("FAIL carry_len: got %0d expected %0d", obs_q.size(), NSYM); else passed++;
    for (int i = 0; i < NSYM && i < obs_q.size(); i++) begin
      want = (!TAIL_EN && i == 0) ? 2'b01 : (!TAIL_EN && i == 1) ? 2'b11 : 2'b00;
      checks++;
      if (obs_q[i] !== want) $display("FAIL carry_sym idx=%0d: got %b expected %b", i, obs_q[i], want);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_mid_frame_reset();
    test_carry_over();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, checks);
    $fatal(1);
  end

endmodule
